ntt_dif_sequencer: RTL and testbench

- Upstream control stage for the modular butterfly unit (a+b, (a−b)·w mod q) in a Gentleman-Sande DIF NTT.
- Walks all LOGN stages of an in-place N-point transform. For each butterfly it issues:
  - two coefficient-memory read addresses;
  - one twiddle-ROM address;
  - an operand-valid strobe aligned to memory read data.
- Issues matching write-back addresses/enables once the butterfly results emerge.
- Drains the pipeline between stages to avoid read-after-write hazards.

---
 rtl/ntt_dif_sequencer.sv | 141 ++++++++++++++
 tb/tb_ntt_dif_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_dif_sequencer.sv
// Control sequencer for an in-place Gentleman-Sande DIF NTT: walks LOGN stages,
// issues butterfly read/twiddle addresses and the matching delayed write-backs.
module ntt_dif_sequencer #(
    parameter int LOGN  = 8,
    parameter int RDLAT = 1,
    parameter int BFLAT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] stage,
    output logic            rd_valid,
    output logic [LOGN-1:0] rd_addr0,
    output logic [LOGN-1:0] rd_addr1,
    output logic [LOGN-2:0] tw_addr,
    output logic            bf_valid,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr0,
    output logic [LOGN-1:0] wr_addr1
);
    localparam int PIPE = RDLAT + BFLAT;
    localparam int CW   = $clog2(PIPE + 1);
    localparam logic [LOGN-2:0] J_LAST = '1;
    localparam logic [LOGN-1:0] S_LAST = LOGN'(LOGN - 1);
    localparam logic [CW-1:0]   D_LAST = CW'(PIPE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_n;
    logic [LOGN-1:0] stage_q, stage_n;
    logic [LOGN-2:0] j_q, j_n;
    logic [CW-1:0]   cnt_q, cnt_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            stage_q <= stage_n;
            j_q     <= j_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        stage_n = stage_q;
        j_n     = j_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_n = ISSUE;
                stage_n = '0;
                j_n     = '0;
            end
            ISSUE: begin
                if (j_q == J_LAST) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    j_n = j_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == D_LAST) begin
                    if (stage_q == S_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage_q + 1'b1;
                        j_n     = '0;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                stage_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign stage    = stage_q;
    assign rd_valid = (state_q == ISSUE);

    // Pair address = j with a zero bit inserted at position log2(len); the mask
    // selects the k field (len-1), so the group field is simply shifted up one.
    logic [LOGN-1:0] mask, jw, k, a0, twf;
    always_comb begin
        mask = ({LOGN{1'b1}} >> 1) >> stage_q;
        jw   = {1'b0, j_q};
        k    = jw & mask;
        a0   = ((jw & ~mask) << 1) | k;
        twf  = k << stage_q;
    end

    assign rd_addr0 = rd_valid ? a0 : '0;
    assign rd_addr1 = rd_valid ? (a0 + mask + 1'b1) : '0;
    assign tw_addr  = rd_valid ? twf[LOGN-2:0] : '0;

    logic [PIPE:1]           vld_pipe;
    logic [PIPE:1][LOGN-1:0] a0_pipe, a1_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            a0_pipe  <= '0;
            a1_pipe  <= '0;
        end else begin
            vld_pipe[1] <= rd_valid;
            a0_pipe[1]  <= rd_addr0;
            a1_pipe[1]  <= rd_addr1;
            for (int i = 2; i <= PIPE; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a0_pipe[i]  <= a0_pipe[i-1];
                a1_pipe[i]  <= a1_pipe[i-1];
            end
        end
    end

    generate
        if (RDLAT == 0) begin : g_bf_comb
            assign bf_valid = rd_valid;
        end else begin : g_bf_pipe
            assign bf_valid = vld_pipe[RDLAT];
        end
    endgenerate

    assign wr_en    = vld_pipe[PIPE];
    assign wr_addr0 = a0_pipe[PIPE];
    assign wr_addr1 = a1_pipe[PIPE];
endmodule

// File: tb/tb_ntt_dif_sequencer.sv
// Randomized bench for ntt_dif_sequencer against a per-cycle arithmetic model
// of the DIF schedule (stage blocks of N/2 issues followed by PIPE drain cycles).
module tb_ntt_dif_sequencer;
    localparam int LOGN  = 4;
    localparam int RDLAT = 1;
    localparam int BFLAT = 8;
    localparam int N     = 1 << LOGN;
    localparam int PIPE  = RDLAT + BFLAT;
    localparam int PER   = N / 2 + PIPE;
    localparam int RUN   = LOGN * PER;

    logic            clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic            busy, done, rd_valid, bf_valid, wr_en;
    logic [LOGN-1:0] stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [LOGN-2:0] tw_addr;
    logic [27:0]     allo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ntt_dif_sequencer #(.LOGN(LOGN), .RDLAT(RDLAT), .BFLAT(BFLAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .stage(stage), .rd_valid(rd_valid), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .tw_addr(tw_addr), .bf_valid(bf_valid), .wr_en(wr_en),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    assign allo = {busy, done, stage, rd_valid, rd_addr0, rd_addr1, tw_addr,
                   bf_valid, wr_en, wr_addr0, wr_addr1};

    typedef struct {
        bit rv, bv, we, busy, done;
        int a0, a1, tw, w0, w1, stage;
    } exp_t;

    // Read issue at cycle c of a run (c0 = first issue cycle).
    function automatic void rd_model(input int c, output bit v, output int a0,
                                     output int a1, output int tw);
        int s, j, len, g, k;
        v = 0; a0 = 0; a1 = 0; tw = 0;
        if (c < 0 || c >= RUN) return;
        s = c / PER;
        j = c % PER;
        if (j >= N / 2) return;
        len = N >> (s + 1);
        g   = j / len;
        k   = j % len;
        v   = 1;
        a0  = g * 2 * len + k;
        a1  = a0 + len;
        tw  = (k << s) % (N / 2);
    endfunction

    function automatic exp_t model(input int c);
        exp_t e;
        int x, y, z;
        rd_model(c, e.rv, e.a0, e.a1, e.tw);
        rd_model(c - RDLAT, e.bv, x, y, z);
        rd_model(c - PIPE, e.we, e.w0, e.w1, z);
        e.busy  = (c >= 0 && c <= RUN);
        e.done  = (c == RUN);
        e.stage = e.busy ? ((c / PER > LOGN - 1) ? LOGN - 1 : c / PER) : 0;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (allo !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", allo);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (allo !== '0) begin
                n_bad++;
                $display("FAIL idle_quiet cyc%0d: got %h want 0", i, allo);
            end
        end
    endtask

    // One full run; optionally pokes start at c30 and at a random busy cycle.
    task automatic test_transform(input int gap, input bit poke);
        exp_t e;
        int   wr_cnt = 0, done_cnt = 0;
        int   rp = $urandom_range(1, RUN - 1);
        repeat (gap) @(negedge clk);
        start = 1'b1;
        for (int c = 0; c <= RUN + 6; c++) begin
            @(negedge clk);
            e = model(c);
            if (wr_en === 1'b1) wr_cnt++;
            if (done === 1'b1) done_cnt++;
            n_cmp++;
            if ({rd_valid, bf_valid, wr_en, busy, done} !== {e.rv, e.bv, e.we, e.busy, e.done}) begin
                n_bad++;
                $display("FAIL ctl c%0d: got rv/bv/we/busy/done=%b want %b", c,
                         {rd_valid, bf_valid, wr_en, busy, done}, {e.rv, e.bv, e.we, e.busy, e.done});
            end
            n_cmp++;
            if (int'(stage) !== e.stage) begin
                n_bad++;
                $display("FAIL stage c%0d: got %0d want %0d", c, stage, e.stage);
            end
            if (e.rv) begin
                n_cmp++;
                if (int'(rd_addr0) !== e.a0 || int'(rd_addr1) !== e.a1 || int'(tw_addr) !== e.tw) begin
                    n_bad++;
                    $display("FAIL rd_addr c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                             rd_addr0, rd_addr1, tw_addr, e.a0, e.a1, e.tw);
                end
            end
            if (e.we) begin
                n_cmp++;
                if (int'(wr_addr0) !== e.w0 || int'(wr_addr1) !== e.w1) begin
                    n_bad++;
                    $display("FAIL wr_addr c%0d: got %0d/%0d want %0d/%0d", c,
                             wr_addr0, wr_addr1, e.w0, e.w1);
                end
            end
            start = poke && (c == 30 || c == rp);
        end
        n_cmp++;
        if (wr_cnt !== LOGN * N / 2 || done_cnt !== 1) begin
            n_bad++;
            $display("FAIL run_totals: got wr=%0d done=%0d want wr=%0d done=1",
                     wr_cnt, done_cnt, LOGN * N / 2);
        end
    endtask

    // Start held high in IDLE: back-to-back runs, one per IDLE visit.
    task automatic test_back_to_back();
        exp_t e;
        int   done_cnt = 0;
        int   drop = $urandom_range(75, 130);
        int   cm;
        start = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            cm = (c < 2 * (RUN + 2)) ? c % (RUN + 2) : 9999;
            e = model(cm);
            if (done === 1'b1) done_cnt++;
            n_cmp++;
            if ({rd_valid, bf_valid, wr_en, busy, done} !== {e.rv, e.bv, e.we, e.busy, e.done}) begin
                n_bad++;
                $display("FAIL b2b_ctl c%0d: got %b want %b", c,
                         {rd_valid, bf_valid, wr_en, busy, done}, {e.rv, e.bv, e.we, e.busy, e.done});
            end
            if (e.rv) begin
                n_cmp++;
                if (int'(rd_addr0) !== e.a0 || int'(rd_addr1) !== e.a1 || int'(tw_addr) !== e.tw) begin
                    n_bad++;
                    $display("FAIL b2b_rd c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                             rd_addr0, rd_addr1, tw_addr, e.a0, e.a1, e.tw);
                end
            end
            if (c == drop) start = 1'b0;
        end
        n_cmp++;
        if (done_cnt !== 2) begin
            n_bad++;
            $display("FAIL b2b_done_count: got %0d want 2", done_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = model(c);
            n_cmp++;
            if ({rd_valid, wr_en, busy} !== {e.rv, e.we, e.busy}) begin
                n_bad++;
                $display("FAIL pre_abort c%0d: got %b want %b", c,
                         {rd_valid, wr_en, busy}, {e.rv, e.we, e.busy});
            end
            start = 1'b0;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (allo !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %h want 0", allo);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wr_en, done, rd_valid, busy} !== 4'b0) begin
                n_bad++;
                $display("FAIL post_abort cyc%0d: got we/done/rv/busy=%b want 0000", i,
                         {wr_en, done, rd_valid, busy});
            end
        end
        test_transform($urandom_range(0, 4), 1'b0);
    endtask

    initial begin
        test_reset();
        test_transform($urandom_range(0, 7), 1'b0);
        test_transform($urandom_range(0, 7), 1'b1);
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
